// File: rtl/pcfx_loader_pkg.sv
// Shared types and helpers for the ioctl-to-SDRAM loaders.
// Holds the FSM state set and the width/alignment configuration check.
package pcfx_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WAIT_ACK,
        FLUSH_WAIT,
        DONE_ST
    } state_t;

    function automatic int lanes(input int ioctl_dw, input int sdram_dw);
        return sdram_dw / ioctl_dw;
    endfunction

    function automatic bit cfg_ok(input int ioctl_dw, input int sdram_dw,
                                  input longint base);
        int r;
        r = lanes(ioctl_dw, sdram_dw);
        return (ioctl_dw == 8 || ioctl_dw == 16)
            && (sdram_dw == ioctl_dw * r)
            && (r == 1 || r == 2 || r == 4)
            && (base % longint'(sdram_dw / 8) == 0);
    endfunction

endpackage

// File: rtl/toggle_handshake.sv
// Toggle req/ack write-port handshake with post-reset resync.
// busy is held low until req has been aligned to ack.
module toggle_handshake (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic ack,
    output logic req,
    output logic busy
);

    logic synced;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= 1'b0;
            synced <= 1'b0;
        end else begin
            synced <= 1'b1;
            // first edge after reset adopts the ack level, so no stray transaction
            if (!synced)
                req <= ack ^ start;
            else if (start)
                req <= ~req;
        end
    end

    assign busy = synced & (req != ack);

endmodule

// File: rtl/ioctl_sdram_loader.sv
// Packs ioctl download words into SDRAM words and writes them
// through the toggle write port, bounded to a region.
module ioctl_sdram_loader
    import pcfx_loader_pkg::*;
#(
    parameter int IOCTL_DW  = 16,
    parameter int SDRAM_DW  = 32,
    parameter int ADDR_W    = 25,
    parameter int INDEX_LO  = 0,
    parameter int INDEX_HI  = 1,
    parameter int BASE_ADDR = 0,
    parameter int MAX_BYTES = 2097152
) (
    input  logic                  clk_sys,
    input  logic                  resn,
    input  logic                  ioctl_download,
    input  logic [7:0]            ioctl_index,
    input  logic                  ioctl_wr,
    input  logic [IOCTL_DW-1:0]   ioctl_dout,
    output logic                  ioctl_wait,
    output logic [ADDR_W-1:0]     sdram_waddr,
    output logic [SDRAM_DW-1:0]   sdram_din,
    output logic [SDRAM_DW/8-1:0] sdram_be,
    output logic                  sdram_we_req,
    input  logic                  sdram_we_ack,
    output logic                  active,
    output logic                  done,
    output logic                  overflow,
    output logic                  proto_err,
    output logic [ADDR_W-1:0]     byte_count
);

    localparam int R          = lanes(IOCTL_DW, SDRAM_DW);
    localparam int LANE_BYTES = IOCTL_DW / 8;
    localparam int WORD_BYTES = SDRAM_DW / 8;
    localparam int BE_W       = SDRAM_DW / 8;

    localparam logic [1:0]        LAST  = 2'(R - 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WSTEP = ADDR_W'(WORD_BYTES);
    localparam logic [ADDR_W-1:0] LSTEP = ADDR_W'(LANE_BYTES);
    localparam logic [63:0]       LIMIT = 64'(BASE_ADDR) + 64'(MAX_BYTES);
    localparam logic [5:0]        LO    = 6'(INDEX_LO);
    localparam logic [5:0]        SPAN  = 6'(INDEX_HI - INDEX_LO);

    generate
        if (!cfg_ok(IOCTL_DW, SDRAM_DW, longint'(BASE_ADDR))) begin : g_cfg_err
            $error("ioctl_sdram_loader: bad width ratio or unaligned base");
        end
    endgenerate

    state_t state, state_n;

    logic                sel, sel_q;
    logic [1:0]          lane, lane_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic [ADDR_W-1:0]   bcnt, bcnt_n;
    logic [SDRAM_DW-1:0] din, din_n;
    logic [BE_W-1:0]     be, be_n;
    logic                wait_q, wait_n;
    logic                active_q, active_n;
    logic                ovf, ovf_n;
    logic                perr, perr_n;
    logic                start, busy, in_bound;
    logic [5:0]          idx_off;
    logic                unused_idx;

    // single unsigned compare covers both ends of the index window
    assign idx_off    = ioctl_index[5:0] - LO;
    assign sel        = ioctl_download & (idx_off <= SPAN);
    assign in_bound   = 64'(addr) < LIMIT;
    assign unused_idx = ^ioctl_index[7:6];

    toggle_handshake u_hs (
        .clk   (clk_sys),
        .rst_n (resn),
        .start (start),
        .ack   (sdram_we_ack),
        .req   (sdram_we_req),
        .busy  (busy)
    );

    always_ff @(posedge clk_sys or negedge resn) begin
        if (!resn) begin
            state    <= IDLE;
            sel_q    <= 1'b0;
            lane     <= 2'd0;
            addr     <= BASE;
            bcnt     <= '0;
            din      <= '0;
            be       <= '0;
            wait_q   <= 1'b0;
            active_q <= 1'b0;
            ovf      <= 1'b0;
            perr     <= 1'b0;
        end else begin
            state    <= state_n;
            sel_q    <= sel;
            lane     <= lane_n;
            addr     <= addr_n;
            bcnt     <= bcnt_n;
            din      <= din_n;
            be       <= be_n;
            wait_q   <= wait_n;
            active_q <= active_n;
            ovf      <= ovf_n;
            perr     <= perr_n;
        end
    end

    always_comb begin
        state_n  = state;
        lane_n   = lane;
        addr_n   = addr;
        bcnt_n   = bcnt;
        din_n    = din;
        be_n     = be;
        wait_n   = wait_q;
        active_n = active_q;
        ovf_n    = ovf;
        perr_n   = perr;
        start    = 1'b0;

        if (ioctl_wr && wait_q)
            perr_n = 1'b1;

        unique case (state)
            IDLE: begin
                if (sel && !sel_q) begin
                    state_n  = FILL;
                    lane_n   = 2'd0;
                    addr_n   = BASE;
                    bcnt_n   = '0;
                    be_n     = '0;
                    ovf_n    = 1'b0;
                    perr_n   = 1'b0;
                    active_n = 1'b1;
                end
            end
            FILL: begin
                if (sel && ioctl_wr) begin
                    din_n[int'(lane)*IOCTL_DW +: IOCTL_DW] = ioctl_dout;
                    be_n[int'(lane)*LANE_BYTES +: LANE_BYTES] = '1;
                    bcnt_n = bcnt + LSTEP;
                    lane_n = lane + 2'd1;
                    if (lane == LAST) begin
                        lane_n = 2'd0;
                        if (in_bound) begin
                            start   = 1'b1;
                            wait_n  = 1'b1;
                            state_n = WAIT_ACK;
                        end else begin
                            ovf_n = 1'b1;
                            be_n  = '0;
                        end
                    end
                end else if (!sel) begin
                    lane_n = 2'd0;
                    if (lane == 2'd0) begin
                        state_n = DONE_ST;
                    end else if (in_bound) begin
                        // partial word keeps only the filled lanes enabled
                        start   = 1'b1;
                        state_n = FLUSH_WAIT;
                    end else begin
                        ovf_n   = 1'b1;
                        be_n    = '0;
                        state_n = DONE_ST;
                    end
                end
            end
            WAIT_ACK: begin
                if (!busy) begin
                    wait_n  = 1'b0;
                    addr_n  = addr + WSTEP;
                    be_n    = '0;
                    state_n = sel ? FILL : DONE_ST;
                end
            end
            FLUSH_WAIT: begin
                if (!busy) begin
                    addr_n  = addr + WSTEP;
                    be_n    = '0;
                    state_n = DONE_ST;
                end
            end
            DONE_ST: begin
                active_n = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ioctl_wait  = wait_q;
    assign sdram_waddr = addr;
    assign sdram_din   = din;
    assign sdram_be    = be;
    assign active      = active_q;
    assign done        = (state == DONE_ST);
    assign overflow    = ovf;
    assign proto_err   = perr;
    assign byte_count  = bcnt;

endmodule

// File: doc/ioctl_sdram_loader.md
Name: ioctl_sdram_loader

Overview:
- Parametrised successor to the top-level ROM/BIOS download path.
- Packs ioctl download words into SDRAM-width words with per-lane byte enables, places them at a configurable base address, and bounds them to a region size.
- Issues writes through the SDRAM toggle req/ack write port and throttles the HPS with ioctl_wait.
- Sits in the clk_sys domain between the ioctl bus and the sdram write-port mux.
- Adds over the existing path: width ratio 1/2/4, partial-word flush at download end, overflow guard, protocol-error flag, and req/ack resync after reset.

Parameters:
- IOCTL_DW, 16, ioctl data width in bits (8 or 16).
- SDRAM_DW, 32, SDRAM word width; must be IOCTL_DW×R with R in {1,2,4}.
- ADDR_W, 25, SDRAM byte-address width.
- INDEX_LO, 0, lowest accepted ioctl_index[5:0].
- INDEX_HI, 1, highest accepted ioctl_index[5:0].
- BASE_ADDR, 0, byte address of the first written word; must be SDRAM_DW/8 aligned.
- MAX_BYTES, 2097152, region size in bytes; writes at or beyond BASE_ADDR+MAX_BYTES are dropped.

Ports:
- clk_sys  in  1  system clock.
- resn  in  1  asynchronous, active-low reset.
- ioctl_download  in  1  HPS download active.
- ioctl_index  in  8  download index; bits [5:0] are compared.
- ioctl_wr  in  1  one-cycle data strobe.
- ioctl_dout  in  IOCTL_DW  download data.
- ioctl_wait  out  1  stall request to the HPS.
- sdram_waddr  out  ADDR_W  write byte address, word aligned.
- sdram_din  out  SDRAM_DW  write data.
- sdram_be  out  SDRAM_DW/8  byte enables, active high.
- sdram_we_req  out  1  write request toggle.
- sdram_we_ack  in  1  write ack toggle; a transaction is done when it equals sdram_we_req.
- active  out  1  an accepted download is in progress.
- done  out  1  one-cycle pulse after the last write of a download is acked.
- overflow  out  1  sticky; at least one word was dropped for region bound.
- proto_err  out  1  sticky; ioctl_wr arrived while ioctl_wait was high.
- byte_count  out  ADDR_W  bytes accepted in the current or last download.

Behaviour:
- Reset values: ioctl_wait=0, sdram_we_req=0, active=0, done=0, overflow=0, proto_err=0, byte_count=0, sdram_waddr=BASE_ADDR, sdram_din=0, sdram_be=0, lane=0.
- Resync: in the first clk_sys edge after resn deasserts, sdram_we_req is loaded from sdram_we_ack. No spurious transaction is issued.
- sel = ioctl_download & INDEX_LO<=ioctl_index[5:0]<=INDEX_HI.
- On a rising edge of sel, registered, the block enters FILL with:
  - lane=0, addr=BASE_ADDR, byte_count=0, be=0;
  - overflow and proto_err cleared;
  - active=1.
- Lane packing, little-endian: ioctl_wr in FILL writes ioctl_dout into sdram_din lane[lane], sets that lane's be bits, adds IOCTL_DW/8 to byte_count, and increments lane.
  - If lane was R-1 (word complete): the next edge toggles sdram_we_req, sets ioctl_wait=1, sets lane=0, and enters WAIT_ACK.
  - Latency from the completing ioctl_wr to the req toggle: 1 cycle.
- Bound check: if addr >= BASE_ADDR+MAX_BYTES when a word completes, no toggle is issued, ioctl_wait stays 0, overflow is set, be is cleared, and the state remains FILL.
- WAIT_ACK: when sdram_we_ack == sdram_we_req:
  - ioctl_wait drops on the next edge;
  - addr advances by SDRAM_DW/8;
  - be is cleared;
  - the state returns to FILL, or to DONE_ST if sel has already fallen.
- Falling edge of sel:
  - in FILL with lane!=0 (partial word): issue one write carrying only the filled lanes' be, then enter FLUSH_WAIT and exit on ack;
  - in FILL with lane==0: go straight to DONE_ST.
- DONE_ST: pulse done for 1 cycle, set active=0, go to IDLE. byte_count holds until the next download start.
- ioctl_wr while ioctl_wait=1: the data is dropped, proto_err is set, and the state is unchanged.
- ioctl_wr outside an accepted download is ignored.
- Address and byte counters wrap modulo 2^ADDR_W. The overflow guard normally prevents reaching the wrap.
- Reset asserted mid-transaction: all state clears immediately and resync applies on release. A partially written SDRAM word is the requester's responsibility.
- States: IDLE, FILL, WAIT_ACK, FLUSH_WAIT, DONE_ST.

Decomposition:
- Shared package pcfx_loader_pkg holds:
  - the state enum;
  - the function lanes(IOCTL_DW,SDRAM_DW);
  - the elaboration check that the width ratio is valid and BASE_ADDR is aligned.
- One natural sub-module, toggle_handshake: owns req, the busy compare, and post-reset resync. It is reused by future loaders.

Test Plan:
- Defaults, index 0, eight halfwords 0x1111..0x8888 with ack 3 cycles after each req:
  - 4 writes at 0x0,0x4,0x8,0xC;
  - first write din=0x22221111, be=0xF;
  - done pulses once;
  - byte_count=16.
- Three halfwords then ioctl_download falls:
  - second write at 0x4, din low half 0x3333, be=0x3;
  - done pulses after its ack.
- MAX_BYTES=8, six halfwords:
  - two writes issued;
  - third word dropped with no req toggle;
  - overflow=1;
  - ioctl_wait never asserted for the dropped word.
- ioctl_wr while ioctl_wait=1:
  - proto_err=1;
  - the following writes are unchanged and addresses are unaffected.
- Force sdram_we_ack=1, pulse resn low mid-WAIT_ACK, release:
  - sdram_we_req==1 one edge after release;
  - no write is issued until new data arrives;
  - ioctl_wait=0.
- IOCTL_DW=8, SDRAM_DW=32, BASE_ADDR=0x100000, index 2 with INDEX_LO=INDEX_HI=2:
  - bytes 0xA0..0xA3 yield din=0xA3A2A1A0 at 0x100000;
  - index 3 is ignored.
